// File: rtl/md_seq.sv
// Multiply/divide step sequencer: drives the P-A datapath through 16 EXEC/SHIFT
// pairs per operation, with a divide pre-check that flags quotient overflow.
module md_seq (
  input  logic       __clk,
  input  logic       clr,
  input  logic       start,
  input  logic       op,
  input  logic       at15,
  input  logic       carry,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic [0:3] cnt,
  output logic       ld,
  output logic       apb,
  output logic       amb,
  output logic       w_ac,
  output logic       as2,
  output logic       eat0
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHK,
    S_EXEC,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic       op_q, op_d;
  logic [0:3] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       eat_q, eat_d;

  always_ff @(posedge __clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      eat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      eat_q   <= eat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    eat_d   = eat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          op_d    = op;
        end
      end
      S_LOAD: begin
        cnt_d   = 4'd15;
        ovf_d   = 1'b0;
        state_d = op_q ? S_CHK : S_EXEC;
      end
      S_CHK: begin
        // No borrow on the trial subtract means the quotient cannot fit.
        if (carry) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        eat_d   = op_q & carry;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_EXEC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    ld   = 1'b0;
    apb  = 1'b0;
    amb  = 1'b0;
    w_ac = 1'b0;
    as2  = 1'b0;
    eat0 = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy = 1'b1;
        ld   = 1'b1;
      end
      S_CHK: begin
        busy = 1'b1;
        amb  = 1'b1;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (op_q) begin
          amb  = 1'b1;
          w_ac = carry;
        end else begin
          apb  = at15;
          w_ac = at15;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        as2  = 1'b1;
        eat0 = eat_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign ovf = ovf_q;
  assign cnt = cnt_q;

endmodule

// File: tb/tb_md_seq.sv
// Cycle-by-cycle vector bench for md_seq: expected outputs per cycle are built
// from the operation timeline and checked through a scoreboard queue.
module tb_md_seq;

  logic       clk;
  logic       clr, start, op, at15, carry;
  logic       busy, done, ovf, ld, apb, amb, w_ac, as2, eat0;
  logic [0:3] cnt;

  md_seq dut (
    .__clk (clk),
    .clr   (clr),
    .start (start),
    .op    (op),
    .at15  (at15),
    .carry (carry),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .cnt   (cnt),
    .ld    (ld),
    .apb   (apb),
    .amb   (amb),
    .w_ac  (w_ac),
    .as2   (as2),
    .eat0  (eat0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr, start, op, at15, carry;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb[$];
  logic        e_ovf;
  logic [3:0]  e_cnt;
  int          n_checks;
  int          n_fails;

  // {busy, done, ovf, cnt[3:0], ld, apb, amb, w_ac, as2, eat0}
  function automatic logic [12:0] pk(input logic b, d, o, input logic [3:0] c,
                                     input logic l, ap, am, w, s, e);
    return {b, d, o, c, l, ap, am, w, s, e};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic cl, st, o, a, cy, input logic [12:0] e);
    vec_t v;
    v.clr = cl; v.start = st; v.op = o; v.at15 = a; v.carry = cy; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [12:0] idle_exp();
    return pk(1'b0, 1'b0, e_ovf, e_cnt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic t_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) add(1'b0, 1'b0, rnd(), rnd(), rnd(), idle_exp());
  endtask

  task automatic t_clr();
    add(1'b1, 1'b1, rnd(), rnd(), rnd(), idle_exp());
    e_ovf = 1'b0;
    e_cnt = 4'd0;
  endtask

  task automatic t_mul(input logic [15:0] pat);
    logic b;
    add(1'b0, 1'b1, 1'b0, rnd(), rnd(), idle_exp());
    add(1'b0, 1'b0, rnd(), rnd(), rnd(), pk(1, 0, e_ovf, e_cnt, 1, 0, 0, 0, 0, 0));
    for (int unsigned k = 0; k < 16; k++) begin
      b = pat[k];
      add(1'b0, 1'b0, rnd(), b, rnd(), pk(1, 0, 0, 4'(15 - k), 0, b, 0, b, 0, 0));
      add(1'b0, 1'b0, rnd(), rnd(), rnd(), pk(1, 0, 0, 4'(15 - k), 0, 0, 0, 0, 1, 0));
    end
    add(1'b0, 1'b0, rnd(), rnd(), rnd(), pk(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0));
    e_ovf = 1'b0;
    e_cnt = 4'd0;
  endtask

  task automatic t_div(input logic chk, input logic [15:0] pat);
    logic b;
    add(1'b0, 1'b1, 1'b1, rnd(), rnd(), idle_exp());
    add(1'b0, 1'b0, rnd(), rnd(), rnd(), pk(1, 0, e_ovf, e_cnt, 1, 0, 0, 0, 0, 0));
    add(1'b0, 1'b0, rnd(), rnd(), chk, pk(1, 0, 0, 4'd15, 0, 0, 1, 0, 0, 0));
    if (chk) begin
      add(1'b0, 1'b0, rnd(), rnd(), rnd(), pk(1, 1, 1, 4'd15, 0, 0, 0, 0, 0, 0));
      e_ovf = 1'b1;
      e_cnt = 4'd15;
    end else begin
      for (int unsigned k = 0; k < 16; k++) begin
        b = pat[k];
        add(1'b0, 1'b0, rnd(), rnd(), b, pk(1, 0, 0, 4'(15 - k), 0, 0, 1, b, 0, 0));
        add(1'b0, 1'b0, rnd(), rnd(), rnd(), pk(1, 0, 0, 4'(15 - k), 0, 0, 0, 0, 1, b));
      end
      add(1'b0, 1'b0, rnd(), rnd(), rnd(), pk(1, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0));
      e_ovf = 1'b0;
      e_cnt = 4'd0;
    end
  endtask

  initial begin
    int unsigned base;
    logic [12:0] act, exp_v;
    logic        seen_done;
    n_checks = 0;
    n_fails  = 0;
    e_ovf    = 1'b0;
    e_cnt    = 4'd0;

    // Reset state, then multiply with starts in LOAD+4 and DONE ignored.
    t_clr();
    t_idle(2);
    base = vecs.size();
    t_mul(16'hA5A5);
    vecs[base + 5].start  = 1'b1;
    vecs[base + 34].start = 1'b1;
    t_idle(2);

    // Divide with alternating quotient bits, then random pattern.
    t_div(1'b0, 16'h5555);
    t_idle(1);
    t_div(1'b0, 16'($urandom));

    // Overflow: ovf sticky in IDLE, cleared by the next LOAD.
    t_idle(1);
    t_div(1'b1, 16'h0);
    t_idle(3);
    t_mul(16'($urandom));
    t_idle(1);

    // Overflow followed by clr.
    t_div(1'b1, 16'h0);
    t_idle(1);
    t_clr();
    t_idle(1);

    // clr at cycle 10 of a multiply, with start also high; restart at cycle 13.
    base = vecs.size();
    t_mul(16'h3C0F);
    while (vecs.size() > base + 11) void'(vecs.pop_back());
    vecs[base + 10].clr   = 1'b1;
    vecs[base + 10].start = 1'b1;
    e_ovf = 1'b0;
    e_cnt = 4'd0;
    t_idle(2);
    t_mul(16'hFFFF);
    t_idle(2);

    clr = 1'b1; start = 1'b0; op = 1'b0; at15 = 1'b0; carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    act = {busy, done, ovf, cnt, ld, apb, amb, w_ac, as2, eat0};
    n_checks++;
    if (act !== 13'b0) begin
      n_fails++;
      $display("FAIL reset state outputs{busy,done,ovf,cnt,ld,apb,amb,w_ac,as2,eat0}: got %b expected %b",
               act, 13'b0);
    end

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      clr   = vecs[i].clr;
      start = vecs[i].start;
      op    = vecs[i].op;
      at15  = vecs[i].at15;
      carry = vecs[i].carry;
      sb.push_back(vecs[i].exp);
      #2;
      exp_v = sb.pop_front();
      act   = {busy, done, ovf, cnt, ld, apb, amb, w_ac, as2, eat0};
      n_checks++;
      if (act !== exp_v) begin
        n_fails++;
        $display("FAIL vec%0d outputs{busy,done,ovf,cnt,ld,apb,amb,w_ac,as2,eat0}: got %b expected %b",
                 i, act, exp_v);
      end
      @(posedge clk);
      #1;
    end

    clr   = 1'b0;
    start = 1'b1;
    op    = 1'b0;
    at15  = 1'b0;
    carry = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (seen_done !== 1'b1) begin
      n_fails++;
      $display("FAIL wait for done expired after 40 cycles");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
